// File: rtl/pipe_pkg.sv
// pipe_pkg: shared FSM state type, control-bundle layout and bubble constant for pipeline stages
package pipe_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   localparam int ALU_OP_W      = 3;
   localparam int FLAG_W        = 1;
   localparam int ALU_OP_OFS    = 0;
   localparam int ALU_SRC_OFS   = ALU_OP_OFS + ALU_OP_W;
   localparam int REG_DST_OFS   = ALU_SRC_OFS + FLAG_W;
   localparam int MEM_WR_OFS    = REG_DST_OFS + FLAG_W;
   localparam int MEM_RD_OFS    = MEM_WR_OFS + FLAG_W;
   localparam int DATA_SRC_OFS  = MEM_RD_OFS + FLAG_W;
   localparam int WR_REG_OFS    = DATA_SRC_OFS + FLAG_W;
   localparam int ZERO_CTL_OFS  = WR_REG_OFS + FLAG_W;
   localparam int CTRL_BUNDLE_W = ZERO_CTL_OFS + FLAG_W;

   localparam logic [CTRL_BUNDLE_W-1:0] CTRL_BUBBLE = '0;

   // True when a control bundle would update architectural state downstream
   function automatic logic ctrl_writes(input logic [CTRL_BUNDLE_W-1:0] c);
      return c[MEM_WR_OFS] | c[WR_REG_OFS];
   endfunction

endpackage

// File: rtl/pipe_slot.sv
// pipe_slot: one payload+control register with load and control-clear
module pipe_slot #(
   parameter int DATA_W = 116,
   parameter int CTRL_W = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              clr,
   input  logic [DATA_W-1:0] d_data,
   input  logic [CTRL_W-1:0] d_ctrl,
   output logic [DATA_W-1:0] q_data,
   output logic [CTRL_W-1:0] q_ctrl
);

   logic [DATA_W-1:0] data_d, data_q;
   logic [CTRL_W-1:0] ctrl_d, ctrl_q;

   // Clearing only touches control so a dropped entry can never write; payload stays stale
   always_comb begin
      data_d = load ? d_data : data_q;
      ctrl_d = clr ? '0 : (load ? d_ctrl : ctrl_q);
   end

   // Slot register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_q <= '0;
         ctrl_q <= '0;
      end else begin
         data_q <= data_d;
         ctrl_q <= ctrl_d;
      end
   end

   assign q_data = data_q;
   assign q_ctrl = ctrl_q;

endmodule

// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: elastic two-entry skid pipeline register with flush and bubble counter
module pipe_stage_buf
   import pipe_pkg::*;
#(
   parameter int DATA_W = 116,
   parameter int CTRL_W = CTRL_BUNDLE_W,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [CNT_W-1:0]  bubble_cnt
);

   state_t            state_q, state_d;
   logic              in_ready_q, in_ready_d;
   logic [CNT_W-1:0]  bubble_cnt_q, bubble_cnt_d;
   logic              in_xfer, out_xfer;
   logic              main_load, skid_load, main_from_skid;
   logic [DATA_W-1:0] main_data, skid_data, main_in_data;
   logic [CTRL_W-1:0] main_ctrl, skid_ctrl, main_in_ctrl;

   assign out_valid = (state_q != EMPTY);

   // Next state, slot loads and registered in_ready; flush overrides every transition
   always_comb begin
      in_xfer        = in_valid & in_ready_q;
      out_xfer       = out_valid & out_ready;
      state_d        = state_q;
      main_load      = 1'b0;
      skid_load      = 1'b0;
      main_from_skid = 1'b0;
      case (state_q)
         EMPTY: begin
            if (in_xfer) begin
               main_load = 1'b1;
               state_d   = ONE;
            end
         end
         ONE: begin
            if (in_xfer && out_xfer) begin
               main_load = 1'b1;
            end else if (in_xfer) begin
               skid_load = 1'b1;
               state_d   = FULL;
            end else if (out_xfer) begin
               state_d = EMPTY;
            end
         end
         FULL: begin
            if (out_xfer) begin
               main_load      = 1'b1;
               main_from_skid = 1'b1;
               state_d        = ONE;
            end
         end
         default: state_d = EMPTY;
      endcase
      if (flush) begin
         state_d        = EMPTY;
         main_load      = 1'b0;
         skid_load      = 1'b0;
         main_from_skid = 1'b0;
      end
      in_ready_d   = (state_d != FULL);
      main_in_data = main_from_skid ? skid_data : in_data;
      main_in_ctrl = main_from_skid ? skid_ctrl : in_ctrl;
   end

   // Saturating count of cycles where downstream was ready but got nothing
   always_comb begin
      bubble_cnt_d = (out_ready && !out_valid && bubble_cnt_q != '1) ? bubble_cnt_q + CNT_W'(1) : bubble_cnt_q;
   end

   // Control state registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= EMPTY;
         in_ready_q   <= 1'b0;
         bubble_cnt_q <= '0;
      end else begin
         state_q      <= state_d;
         in_ready_q   <= in_ready_d;
         bubble_cnt_q <= bubble_cnt_d;
      end
   end

   pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_main (
      .clk    (clk),
      .rst    (rst),
      .load   (main_load),
      .clr    (flush),
      .d_data (main_in_data),
      .d_ctrl (main_in_ctrl),
      .q_data (main_data),
      .q_ctrl (main_ctrl)
   );

   pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_skid (
      .clk    (clk),
      .rst    (rst),
      .load   (skid_load),
      .clr    (flush),
      .d_data (in_data),
      .d_ctrl (in_ctrl),
      .q_data (skid_data),
      .q_ctrl (skid_ctrl)
   );

   assign in_ready   = in_ready_q;
   assign out_data   = main_data;
   assign out_ctrl   = out_valid ? main_ctrl : CTRL_W'(CTRL_BUBBLE);
   assign bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb_pipe_stage_buf: table-driven and scoreboard checks for pipe_stage_buf
module tb_pipe_stage_buf;
   import pipe_pkg::*;

   localparam int DW = 16;
   localparam int CW = 10;
   localparam int NW = 4;

   typedef struct {
      logic          iv;
      logic [DW-1:0] id;
      logic [CW-1:0] ic;
      logic          ordy;
      logic          fl;
      logic          e_ov;
      logic [DW-1:0] e_od;
      logic          e_ir;
   } vec_t;

   typedef struct packed {
      logic [DW-1:0] d;
      logic [CW-1:0] c;
   } ent_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid, in_ready, flush, out_valid, out_ready;
   logic [DW-1:0] in_data, out_data;
   logic [CW-1:0] in_ctrl, out_ctrl;
   logic [NW-1:0] bubble_cnt;

   int   pass_cnt = 0;
   int   chk_cnt  = 0;
   int   n_out    = 0;
   ent_t sb[$];
   vec_t tbl[$];

   pipe_stage_buf #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(NW)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .in_ctrl    (in_ctrl),
      .flush      (flush),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_ctrl   (out_ctrl),
      .bubble_cnt (bubble_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      chk_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   function automatic vec_t v(input logic iv, input logic [DW-1:0] id, input logic [CW-1:0] ic,
                              input logic ordy, input logic fl, input logic e_ov,
                              input logic [DW-1:0] e_od, input logic e_ir);
      vec_t r;
      r.iv = iv; r.id = id; r.ic = ic; r.ordy = ordy; r.fl = fl;
      r.e_ov = e_ov; r.e_od = e_od; r.e_ir = e_ir;
      return r;
   endfunction

   task automatic drive(input logic iv, input logic [DW-1:0] id, input logic [CW-1:0] ic,
                        input logic ordy, input logic fl);
      in_valid = iv; in_data = id; in_ctrl = ic; out_ready = ordy; flush = fl;
      #1;
   endtask

   task automatic apply(input vec_t r, input string tag);
      drive(r.iv, r.id, r.ic, r.ordy, r.fl);
      chk({tag, "_ov"}, out_valid, r.e_ov);
      if (r.e_ov) chk({tag, "_od"}, out_data, r.e_od);
      chk({tag, "_ir"}, in_ready, r.e_ir);
   endtask

   // Scoreboard bookkeeping for the upcoming edge, then advance to the next negedge
   task automatic step();
      ent_t e;
      logic ix, ox;
      ix = in_valid & in_ready;
      ox = out_valid & out_ready;
      if (ox) begin
         n_out++;
         chk("sb_has_entry", sb.size() > 0, 1);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("sb_data", out_data, e.d);
            chk("sb_ctrl", out_ctrl, e.c);
         end
      end
      if (flush) sb.delete();
      else if (ix) sb.push_back({in_data, in_ctrl});
      @(negedge clk);
   endtask

   task automatic run_tbl(input string tag);
      for (int i = 0; i < tbl.size(); i++) begin
         apply(tbl[i], $sformatf("%s%0d", tag, i));
         step();
      end
   endtask

   initial begin
      int n0;
      rst = 1'b1;
      drive(0, '0, '0, 0, 0);
      repeat (2) @(negedge clk);
      #1;
      chk("rst_ov", out_valid, 0);
      chk("rst_octrl", out_ctrl, 0);
      chk("rst_od", out_data, 0);
      chk("rst_ir", in_ready, 0);
      chk("rst_bub", bubble_cnt, 0);
      rst = 1'b0;
      #1;
      chk("rel_ir_low", in_ready, 0);
      @(posedge clk);
      #1;
      chk("rel_ir_high", in_ready, 1);
      @(negedge clk);

      tbl.delete();
      for (int i = 0; i < 10; i++)
         tbl.push_back(v(i < 8, DW'(i), CW'(10'h040 | i), 1, 0, i >= 1 && i <= 8, DW'(i - 1), 1));
      for (int i = 0; i < tbl.size(); i++) begin
         apply(tbl[i], $sformatf("stream%0d", i));
         if (i == 1 || i == 9) chk("stream_bub", bubble_cnt, 1);
         step();
      end

      tbl.delete();
      tbl.push_back(v(1, 16'hA, 10'h10A, 1, 0, 0, 16'h0, 1));
      tbl.push_back(v(1, 16'hB, 10'h10B, 0, 0, 1, 16'hA, 1));
      tbl.push_back(v(1, 16'hC, 10'h10C, 0, 0, 1, 16'hA, 0));
      tbl.push_back(v(1, 16'hC, 10'h10C, 1, 0, 1, 16'hA, 0));
      tbl.push_back(v(1, 16'hC, 10'h10C, 1, 0, 1, 16'hB, 1));
      tbl.push_back(v(1, 16'hD, 10'h10D, 1, 0, 1, 16'hC, 1));
      tbl.push_back(v(0, 16'h0, 10'h000, 1, 0, 1, 16'hD, 1));
      tbl.push_back(v(0, 16'h0, 10'h000, 1, 0, 0, 16'h0, 1));
      run_tbl("bp");
      chk("bp_drained", sb.size(), 0);

      n0 = n_out;
      apply(v(1, 16'hE, 10'h20E, 0, 0, 0, 16'h0, 1), "fl0"); step();
      apply(v(1, 16'hF, 10'h20F, 0, 0, 1, 16'hE, 1), "fl1"); step();
      apply(v(1, 16'h6, 10'h206, 1, 1, 1, 16'hE, 0), "fl2"); step();
      apply(v(1, 16'h6, 10'h206, 1, 0, 0, 16'h0, 1), "fl3");
      chk("fl3_octrl", out_ctrl, 0);
      step();
      apply(v(1, 16'h7, 10'h207, 0, 1, 1, 16'h6, 1), "fl4"); step();
      apply(v(0, 16'h0, 10'h000, 1, 0, 0, 16'h0, 1), "fl5");
      chk("fl5_octrl", out_ctrl, 0);
      step();
      apply(v(0, 16'h0, 10'h000, 1, 0, 0, 16'h0, 1), "fl6"); step();
      chk("fl_out_once", n_out - n0, 1);
      chk("fl_sb_empty", sb.size(), 0);

      for (int i = 0; i < 4; i++) begin
         apply(v(0, 16'h0, 10'h3FF, 1, 0, 0, 16'h0, 1), $sformatf("cbub%0d", i));
         chk("cbub_octrl", out_ctrl, 0);
         chk("cbub_nowrite", ctrl_writes(out_ctrl), 0);
         step();
      end

      drive(1, 16'h55, 10'h155, 0, 0);
      step();
      drive(0, '0, '0, 0, 0);
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("mrst_ov", out_valid, 0);
      chk("mrst_octrl", out_ctrl, 0);
      chk("mrst_od", out_data, 0);
      chk("mrst_ir", in_ready, 0);
      sb.delete();
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("mrel_ir_low", in_ready, 0);
      @(posedge clk);
      #1;
      chk("mrel_ir_high", in_ready, 1);
      @(negedge clk);

      for (int i = 0; i < 21; i++) begin
         drive(0, '0, '0, 1, 0);
         if (i == 10) chk("bub_mid", bubble_cnt, 10);
         step();
      end
      #1;
      chk("bub_sat", bubble_cnt, 15);
      chk("final_sb_empty", sb.size(), 0);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
